// File: rtl/irq_coalesce_ctrl_pkg.sv
// Shared types and helpers for the interrupt coalescing controller:
// FSM state encoding, id-width helper and a saturating-increment macro.
`ifndef IRQ_COALESCE_CTRL_PKG_SV
`define IRQ_COALESCE_CTRL_PKG_SV

// Adds inc (0/1) to v, holding at all-ones instead of wrapping.
`define IRQ_SAT_ADD1(v, inc) ((((inc) != 1'b0) && !(&(v))) ? ((v) + 1'b1) : (v))

package irq_coalesce_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FIRE    = 2'd2
  } irq_state_e;

  function automatic int irq_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`endif

// File: rtl/irq_coalesce_ctrl_if.sv
// Bus bundle between the register block / source IPs and the coalescing controller.
interface irq_coalesce_ctrl_if
  import irq_coalesce_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 16
);
  localparam int ID_W = irq_id_w(NUM_SRC);

  // No valid/ready pairing: src/edge_mode/enable/thresholds are level controls
  // sampled every cycle, clr is a one-cycle write-1-to-clear strobe per bit.
  logic [NUM_SRC-1:0] src;
  logic [NUM_SRC-1:0] edge_mode;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] clr;
  logic [CNT_W-1:0]   coal_thresh;
  logic [TMO_W-1:0]   coal_tmo;
  logic               irq;
  logic [NUM_SRC-1:0] pending;
  logic [ID_W-1:0]    irq_id;
  logic               irq_id_vld;

  modport master (
    output src, edge_mode, enable, clr, coal_thresh, coal_tmo,
    input  irq, pending, irq_id, irq_id_vld
  );

  modport slave (
    input  src, edge_mode, enable, clr, coal_thresh, coal_tmo,
    output irq, pending, irq_id, irq_id_vld
  );
endinterface

// File: rtl/irq_coalesce_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set index wins, valid when any bit is set.
module irq_prio_enc
  import irq_coalesce_ctrl_pkg::*;
#(
  parameter int N    = 8,
  parameter int ID_W = irq_id_w(N)
) (
  input  logic [N-1:0]    i_req,
  output logic [ID_W-1:0] o_id,
  output logic            o_vld
);
  always_comb begin
    o_id  = '0;
    o_vld = |i_req;
    // Scan downward so the lowest requesting index is the last write.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_id = ID_W'(i);
    end
  end
endmodule

// File: rtl/irq_coalesce_ctrl.sv
// Multi-source interrupt aggregator: edge/level event detect, W1C pending latches,
// count/timeout coalescing FSM driving one CPU irq line plus a priority source id.
module irq_coalesce_ctrl
  import irq_coalesce_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  irq_coalesce_ctrl_if.slave   bus,
  output irq_state_e           o_state
);
  localparam int ID_W = irq_id_w(NUM_SRC);

  logic [NUM_SRC-1:0] r_src_q;
  logic [NUM_SRC-1:0] r_pending;
  logic               r_new_evt;
  irq_state_e         r_state;
  logic [CNT_W-1:0]   r_evt_cnt;
  logic [TMO_W-1:0]   r_tmo_cnt;

  logic [NUM_SRC-1:0] w_evt;
  logic [NUM_SRC-1:0] w_pend_nxt;
  logic [NUM_SRC-1:0] w_act_vec;
  logic               w_act;
  logic [CNT_W:0]     w_cnt_sum;
  logic [TMO_W:0]     w_tmo_sum;
  logic               w_thresh_hit;
  logic               w_tmo_hit;
  logic               w_thresh_le1;
  logic [ID_W-1:0]    w_irq_id;
  logic               w_irq_id_vld;

  assign w_evt        = bus.src & (~bus.edge_mode | ~r_src_q);
  assign w_pend_nxt   = w_evt | (r_pending & ~bus.clr);
  assign w_act_vec    = r_pending & bus.enable;
  assign w_act        = |w_act_vec;
  assign w_cnt_sum    = {1'b0, r_evt_cnt} + (CNT_W + 1)'(r_new_evt);
  assign w_tmo_sum    = {1'b0, r_tmo_cnt} + (TMO_W + 1)'(1);
  assign w_thresh_hit = w_cnt_sum >= {1'b0, bus.coal_thresh};
  assign w_tmo_hit    = (bus.coal_tmo != '0) && (w_tmo_sum >= {1'b0, bus.coal_tmo});
  assign w_thresh_le1 = bus.coal_thresh <= CNT_W'(1);

  // The FSM sees events one cycle late (via r_pending / r_new_evt) so irq
  // follows pending by one cycle and never has a combinational path from src.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_q   <= '0;
      r_pending <= '0;
      r_new_evt <= 1'b0;
    end else begin
      r_src_q   <= bus.src;
      r_pending <= w_pend_nxt;
      r_new_evt <= |(w_evt & bus.enable & ~r_pending);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_evt_cnt <= '0;
      r_tmo_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_act) begin
            if (w_thresh_le1) begin
              r_state <= FIRE;
            end else begin
              r_state   <= COLLECT;
              r_evt_cnt <= CNT_W'(1);
              r_tmo_cnt <= '0;
            end
          end
        end
        COLLECT: begin
          if (!w_act) begin
            r_state   <= IDLE;
            r_evt_cnt <= '0;
            r_tmo_cnt <= '0;
          end else if (w_thresh_hit || w_tmo_hit) begin
            r_state <= FIRE;
          end else begin
            r_evt_cnt <= `IRQ_SAT_ADD1(r_evt_cnt, r_new_evt);
            r_tmo_cnt <= `IRQ_SAT_ADD1(r_tmo_cnt, 1'b1);
          end
        end
        FIRE: begin
          // New events here only latch pending; the line is already up.
          if (!w_act) begin
            r_state   <= IDLE;
            r_evt_cnt <= '0;
            r_tmo_cnt <= '0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_evt_cnt <= '0;
          r_tmo_cnt <= '0;
        end
      endcase
    end
  end

  irq_prio_enc #(
    .N    (NUM_SRC),
    .ID_W (ID_W)
  ) u_prio_enc (
    .i_req (w_act_vec),
    .o_id  (w_irq_id),
    .o_vld (w_irq_id_vld)
  );

  assign bus.irq        = (r_state == FIRE);
  assign bus.pending    = r_pending;
  assign bus.irq_id     = w_irq_id;
  assign bus.irq_id_vld = w_irq_id_vld;
  assign o_state        = r_state;
endmodule
